seq_stuff_tx: RTL and testbench

Serial bit-stuffing transmitter. It accepts a parallel word over a valid/ready handshake and shifts it out MSB-first, one bit per clock. Whenever the line carries MAX_RUN consecutive identical bits, it inserts one complement bit so no run exceeds MAX_RUN. It is the sending end of the serial run-detection path and feeds the consecutive-bit detector/receiver on in_bit.

---
 rtl/seq_pkg.sv | 29 ++
 rtl/seq_run_tracker.sv | 46 ++++
 rtl/seq_stuff_tx.sv | 172 +++++++++++++++++
 tb/tb_seq_stuff_tx.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the serial bit-stuffing path: FSM encoding and a
// constant-evaluable ceil(log2) helper used to size counters.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_STUFF = 2'b10
    } state_t;

    // Number of bits needed to index 'value' distinct items (minimum 1).
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        if (result == 0) begin
            result = 1;
        end else begin
            result = result;
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_run_tracker.sv
// Line-history tracker: remembers the last line bit and the length of the
// current run of identical bits, and flags when a complement must be forced.
module seq_run_tracker
    import seq_pkg::*;
#(
    parameter int MAX_RUN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_en,
    input  logic bit_val,
    output logic stuff_req,
    output logic last_bit
);

    localparam int RUN_W = clog2(MAX_RUN + 1);

    logic [RUN_W-1:0] run_cnt_r;
    logic             last_bit_r;

    // Track the run of identical bits on the line; stuffed bits count too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_bit_r <= 1'b0;
            run_cnt_r  <= {RUN_W{1'b0}};
        end else if (bit_en) begin
            last_bit_r <= bit_val;
            if ((bit_val != last_bit_r) || (run_cnt_r == {RUN_W{1'b0}})) begin
                run_cnt_r <= RUN_W'(1);
            end else if (run_cnt_r != RUN_W'(MAX_RUN)) begin
                run_cnt_r <= run_cnt_r + RUN_W'(1);
            end else begin
                // A full run is always broken by a stuffed complement first,
                // so this hold only keeps the counter from ever wrapping.
                run_cnt_r <= run_cnt_r;
            end
        end else begin
            last_bit_r <= last_bit_r;
            run_cnt_r  <= run_cnt_r;
        end
    end

    assign stuff_req = (run_cnt_r == RUN_W'(MAX_RUN));
    assign last_bit  = last_bit_r;

endmodule

// File: rtl/seq_stuff_tx.sv
// Serial bit-stuffing transmitter: accepts a word on valid/ready, shifts it
// out MSB-first and inserts a complement bit after every MAX_RUN identical
// line bits. All outputs are registered.
module seq_stuff_tx
    import seq_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int MAX_RUN = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_bit,
    output logic              out_valid,
    output logic              out_stuff,
    output logic              out_sof,
    output logic              busy
);

    localparam int IDX_W = clog2(DATA_W) + 1;

    state_t            state_r;
    logic [DATA_W-1:0] shreg_r;
    logic [IDX_W-1:0]  idx_r;      // data bits still to be emitted

    logic emit_en_s;
    logic emit_bit_s;
    logic stuff_req_s;
    logic last_bit_s;

    seq_run_tracker #(
        .MAX_RUN (MAX_RUN)
    ) u_run_tracker (
        .clk       (clk),
        .rst       (rst),
        .bit_en    (emit_en_s),
        .bit_val   (emit_bit_s),
        .stuff_req (stuff_req_s),
        .last_bit  (last_bit_s)
    );

    // Choose the line bit launched at the next edge (shared by FSM and tracker).
    always_comb begin
        emit_en_s  = 1'b0;
        emit_bit_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    emit_en_s  = 1'b1;
                    emit_bit_s = in_data[DATA_W-1];
                end else begin
                    emit_en_s  = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (stuff_req_s) begin
                    emit_en_s  = 1'b1;
                    emit_bit_s = ~last_bit_s;
                end else if (idx_r != {IDX_W{1'b0}}) begin
                    emit_en_s  = 1'b1;
                    emit_bit_s = shreg_r[DATA_W-1];
                end else begin
                    emit_en_s  = 1'b0;
                end
            end
            ST_STUFF: begin
                if (idx_r != {IDX_W{1'b0}}) begin
                    emit_en_s  = 1'b1;
                    emit_bit_s = shreg_r[DATA_W-1];
                end else begin
                    emit_en_s  = 1'b0;
                end
            end
            default: begin
                emit_en_s  = 1'b0;
            end
        endcase
    end

    // Word FSM with shift register and registered line outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            shreg_r   <= {DATA_W{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            in_ready  <= 1'b1;
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
            out_stuff <= 1'b0;
            out_sof   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        shreg_r   <= in_data << 1;
                        idx_r     <= IDX_W'(DATA_W - 1);
                        out_bit   <= emit_bit_s;
                        out_valid <= 1'b1;
                        out_stuff <= 1'b0;
                        out_sof   <= 1'b1;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state_r   <= ST_SHIFT;
                    end else begin
                        out_valid <= 1'b0;
                        out_stuff <= 1'b0;
                        out_sof   <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (stuff_req_s) begin
                        // Run just hit the limit (possibly on the last data
                        // bit): force the complement before anything else.
                        out_bit   <= emit_bit_s;
                        out_valid <= 1'b1;
                        out_stuff <= 1'b1;
                        out_sof   <= 1'b0;
                        state_r   <= ST_STUFF;
                    end else if (idx_r != {IDX_W{1'b0}}) begin
                        shreg_r   <= {shreg_r[DATA_W-2:0], 1'b0};
                        idx_r     <= idx_r - IDX_W'(1);
                        out_bit   <= emit_bit_s;
                        out_valid <= 1'b1;
                        out_stuff <= 1'b0;
                        out_sof   <= 1'b0;
                        state_r   <= ST_SHIFT;
                    end else begin
                        out_valid <= 1'b0;
                        out_stuff <= 1'b0;
                        out_sof   <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                ST_STUFF: begin
                    if (idx_r != {IDX_W{1'b0}}) begin
                        shreg_r   <= {shreg_r[DATA_W-2:0], 1'b0};
                        idx_r     <= idx_r - IDX_W'(1);
                        out_bit   <= emit_bit_s;
                        out_valid <= 1'b1;
                        out_stuff <= 1'b0;
                        out_sof   <= 1'b0;
                        state_r   <= ST_SHIFT;
                    end else begin
                        out_valid <= 1'b0;
                        out_stuff <= 1'b0;
                        out_sof   <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    out_stuff <= 1'b0;
                    out_sof   <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_stuff_tx.sv
// Directed bench for seq_stuff_tx (DATA_W=8, MAX_RUN=3) with hand-computed
// line sequences; outputs are sampled on the falling clock edge.
module tb_seq_stuff_tx;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       out_bit;
    logic       out_valid;
    logic       out_stuff;
    logic       out_sof;
    logic       busy;

    int vectors;
    int miscompares;

    seq_stuff_tx #(
        .DATA_W  (8),
        .MAX_RUN (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .out_stuff (out_stuff),
        .out_sof   (out_sof),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst in_ready", 16'(in_ready), 16'd1);
        chk("rst out_valid", 16'(out_valid), 16'd0);
        chk("rst out_bit", 16'(out_bit), 16'd0);
        chk("rst out_stuff", 16'(out_stuff), 16'd0);
        chk("rst out_sof", 16'(out_sof), 16'd0);
        chk("rst busy", 16'(busy), 16'd0);
        rst = 1'b0;
    endtask

    // Present one word for a single accepting edge; returns on the negedge
    // where the first line bit is already visible.
    task automatic send(input logic [7:0] w);
        @(negedge clk);
        in_data  = w;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h3C;
    endtask

    // Check n consecutive line bits (bits/stf listed MSB = first on line).
    task automatic check_word(input string tag, input int n,
                              input logic [15:0] bits, input logic [15:0] stf);
        int wait_cnt;
        wait_cnt = 0;
        while (out_valid !== 1'b1 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk($sformatf("%s start", tag), 16'(out_valid), 16'd1);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s valid[%0d]", tag, i), 16'(out_valid), 16'd1);
            chk($sformatf("%s bit[%0d]", tag, i), 16'(out_bit), 16'(bits[n-1-i]));
            chk($sformatf("%s stuff[%0d]", tag, i), 16'(out_stuff), 16'(stf[n-1-i]));
            chk($sformatf("%s sof[%0d]", tag, i), 16'(out_sof), (i == 0) ? 16'd1 : 16'd0);
            chk($sformatf("%s busy[%0d]", tag, i), 16'(busy), 16'd1);
            chk($sformatf("%s ready[%0d]", tag, i), 16'(in_ready), 16'd0);
            @(negedge clk);
        end
        chk($sformatf("%s end valid", tag), 16'(out_valid), 16'd0);
        chk($sformatf("%s end ready", tag), 16'(in_ready), 16'd1);
        chk($sformatf("%s end busy", tag), 16'(busy), 16'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        in_data     = 8'h00;
        in_valid    = 1'b0;
        #12;

        // 1: A5 after reset, no stuffing
        do_reset();
        send(8'hA5);
        check_word("A5", 8, 16'b10100101, 16'b00000000);

        // 2: FF after reset -> 1,1,1,0s,1,1,1,0s,1,1
        do_reset();
        send(8'hFF);
        check_word("FF", 10, 16'b1110111011, 16'b0001000100);

        // 3: 00 after the FF, history (last=1, run=2) carried over the gap
        repeat (3) @(negedge clk);
        send(8'h00);
        check_word("00", 10, 16'b0001000100, 16'b0001000100);

        // 4: E0 -> 1,1,1,0s,0,0,1s,0,0,0,1s (trailing stuff)
        do_reset();
        send(8'hE0);
        check_word("E0", 11, 16'b11100010001, 16'b00010010001);

        // 5: in_valid held with changing in_data during an FF word
        do_reset();
        @(negedge clk);
        in_data  = 8'hFF;
        in_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("hold bit[%0d]", i), 16'(out_bit),
                ((i == 3) || (i == 7)) ? 16'd0 : 16'd1);
            chk($sformatf("hold stuff[%0d]", i), 16'(out_stuff),
                ((i == 3) || (i == 7)) ? 16'd1 : 16'd0);
            chk($sformatf("hold sof[%0d]", i), 16'(out_sof), (i == 0) ? 16'd1 : 16'd0);
            chk($sformatf("hold ready[%0d]", i), 16'(in_ready), 16'd0);
            in_data = 8'($urandom);
            @(negedge clk);
        end
        chk("hold gap valid", 16'(out_valid), 16'd0);
        chk("hold gap ready", 16'(in_ready), 16'd1);
        in_data = 8'h00;
        @(negedge clk);
        chk("hold next valid", 16'(out_valid), 16'd1);
        chk("hold next sof", 16'(out_sof), 16'd1);
        chk("hold next bit", 16'(out_bit), 16'd0);
        chk("hold next stuff", 16'(out_stuff), 16'd0);
        in_valid = 1'b0;
        repeat (15) @(negedge clk);
        chk("hold drain busy", 16'(busy), 16'd0);

        // 6: reset during the 4th line bit (a stuff) of FF, then 1F
        do_reset();
        send(8'hFF);
        repeat (3) @(negedge clk);
        chk("abort 4th stuff", 16'(out_stuff), 16'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort valid", 16'(out_valid), 16'd0);
        chk("abort busy", 16'(busy), 16'd0);
        chk("abort ready", 16'(in_ready), 16'd1);
        chk("abort stuff", 16'(out_stuff), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        // 0,0,0,1s,1,1,0s,1,1,1,0s : the stuffed 1 starts the run of ones
        send(8'h1F);
        check_word("1F", 11, 16'b00011101110, 16'b00010010001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
